// File: rtl/tappy_core.sv
// tappy_core: PS/2-style serial receiver oversampled in the sysclk domain.
// Rebuilds start/data/odd-parity/stop frames into words with a done strobe.
module tappy_core #(
   parameter int DATA_BITS    = 8,
   parameter int SYNC_STAGES  = 2,
   parameter int IDLE_TIMEOUT = 32
) (
   input  logic                 sysclk,
   input  logic                 reset,
   input  logic                 clk,
   input  logic                 dat,
   output logic [DATA_BITS-1:0] word,
   output logic                 done
);

   localparam int IW = $clog2(DATA_BITS);
   localparam int TW = $clog2(IDLE_TIMEOUT + 1);

   typedef enum logic [1:0] {
      IDLE,
      DATA,
      PARITY,
      STOP
   } state_t;

   state_t               state, state_n;
   logic [1:0]           rst_sync;
   logic                 rst_i;
   logic [SYNC_STAGES-1:0] clk_s, dat_s;
   logic                 clk_prev;
   logic                 fall, bit_in;
   logic [DATA_BITS-1:0] shreg, shreg_n;
   logic [IW-1:0]        cnt, cnt_n;
   logic                 par, par_n;
   logic [TW-1:0]        tcnt, tcnt_n;
   logic                 load;

   // Assert immediately, release on sysclk.
   always_ff @(posedge sysclk or posedge reset) begin
      if (reset) rst_sync <= 2'b11;
      else       rst_sync <= {rst_sync[0], 1'b0};
   end

   assign rst_i = rst_sync[1];

   always_ff @(posedge sysclk or posedge rst_i) begin
      if (rst_i) begin
         clk_s    <= '1;
         dat_s    <= '1;
         clk_prev <= 1'b1;
      end else begin
         clk_s    <= {clk_s[SYNC_STAGES-2:0], clk};
         dat_s    <= {dat_s[SYNC_STAGES-2:0], dat};
         clk_prev <= clk_s[SYNC_STAGES-1];
      end
   end

   assign fall   = clk_prev & ~clk_s[SYNC_STAGES-1];
   assign bit_in = dat_s[SYNC_STAGES-1];

   always_comb begin
      state_n = state;
      shreg_n = shreg;
      cnt_n   = cnt;
      par_n   = par;
      tcnt_n  = tcnt;
      load    = 1'b0;
      if (fall) begin
         tcnt_n = '0;
         unique case (state)
            IDLE: begin
               if (!bit_in) begin
                  state_n = DATA;
                  cnt_n   = '0;
                  shreg_n = '0;
               end
            end
            DATA: begin
               shreg_n[cnt] = bit_in;
               if (cnt == IW'(DATA_BITS - 1)) state_n = PARITY;
               else                           cnt_n   = cnt + IW'(1);
            end
            PARITY: begin
               par_n   = bit_in;
               state_n = STOP;
            end
            STOP: begin
               load    = bit_in & (^{shreg, par});
               state_n = IDLE;
            end
            default: state_n = IDLE;
         endcase
      end else if (state != IDLE) begin
         // Stalled frame: drop the partial byte.
         if (tcnt == TW'(IDLE_TIMEOUT - 1)) begin
            state_n = IDLE;
            tcnt_n  = '0;
         end else begin
            tcnt_n = tcnt + TW'(1);
         end
      end
   end

   always_ff @(posedge sysclk or posedge rst_i) begin
      if (rst_i) begin
         state <= IDLE;
         shreg <= '0;
         cnt   <= '0;
         par   <= 1'b0;
         tcnt  <= '0;
         word  <= '0;
         done  <= 1'b0;
      end else begin
         state <= state_n;
         shreg <= shreg_n;
         cnt   <= cnt_n;
         par   <= par_n;
         tcnt  <= tcnt_n;
         done  <= load;
         if (load) word <= shreg;
      end
   end

endmodule

// File: tb/tb_tappy_core.sv
// tb_tappy_core: vector table, corner sequences and randomized frames
// for the PS/2-style receiver, checked against a frame-level model.
module tb_tappy_core;

   logic       sysclk = 1'b0;
   logic       reset  = 1'b1;
   logic       clk    = 1'b1;
   logic       dat    = 1'b1;
   logic [7:0] word;
   logic       done;

   int checks = 0;
   int errors = 0;

   logic [7:0] got[$];
   logic [7:0] expq[$];
   logic       prev_done = 1'b0;

   typedef struct {
      logic [7:0] data;
      bit         par_ok;
      bit         stop_ok;
      int         half;
      int         exp_n;
      logic [7:0] exp_word;
   } vec_t;

   vec_t tbl[4];

   tappy_core #(
      .DATA_BITS(8),
      .SYNC_STAGES(2),
      .IDLE_TIMEOUT(32)
   ) dut (
      .sysclk(sysclk),
      .reset (reset),
      .clk   (clk),
      .dat   (dat),
      .word  (word),
      .done  (done)
   );

   always #5 sysclk = ~sysclk;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // done must be a single-cycle pulse; log each reported word.
   always @(negedge sysclk) begin
      if (!reset) begin
         if (done) begin
            got.push_back(word);
            chk("done_width", int'(prev_done), 0);
         end
         prev_done <= done;
      end else begin
         prev_done <= 1'b0;
      end
   end

   function automatic logic [10:0] mkframe(input logic [7:0] d,
                                           input bit pok,
                                           input bit sok);
      logic p;
      p = ~(^d);
      if (!pok) p = ~p;
      return {sok ? 1'b1 : 1'b0, p, d, 1'b0};
   endfunction

   task automatic send_bits(input logic [10:0] f, input int n, input int h);
      for (int i = 0; i < n; i++) begin
         @(negedge sysclk);
         dat = f[i];
         repeat (h) @(negedge sysclk);
         clk = 1'b0;
         repeat (h) @(negedge sysclk);
         clk = 1'b1;
      end
      dat = 1'b1;
   endtask

   task automatic settle();
      repeat (12) @(negedge sysclk);
   endtask

   initial begin
      tbl[0] = '{8'h55, 1'b1, 1'b1, 6, 1, 8'h55};
      tbl[1] = '{8'h3C, 1'b0, 1'b1, 10, 0, 8'hFF};
      tbl[2] = '{8'h12, 1'b1, 1'b0, 10, 0, 8'hFF};
      tbl[3] = '{8'h34, 1'b1, 1'b1, 6, 1, 8'h34};

      repeat (4) @(negedge sysclk);
      chk("rst_word", int'(word), 0);
      chk("rst_done", int'(done), 0);
      reset = 1'b0;
      repeat (6) @(negedge sysclk);
      chk("post_rst_word", int'(word), 0);

      for (int i = 0; i < 4; i++) begin
         got.delete();
         send_bits(mkframe(tbl[i].data, tbl[i].par_ok, tbl[i].stop_ok),
                   11, tbl[i].half);
         settle();
         chk($sformatf("vec%0d_n", i), got.size(), tbl[i].exp_n);
         chk($sformatf("vec%0d_word", i), int'(word), int'(tbl[i].exp_word));
         if (i == 0) begin
            // Back-to-back frames at the slow rate.
            got.delete();
            send_bits(mkframe(8'hA5, 1, 1), 11, 10);
            send_bits(mkframe(8'h00, 1, 1), 11, 10);
            send_bits(mkframe(8'hFF, 1, 1), 11, 10);
            settle();
            chk("b2b_n", got.size(), 3);
            if (got.size() == 3) begin
               chk("b2b_0", int'(got[0]), 8'hA5);
               chk("b2b_1", int'(got[1]), 8'h00);
               chk("b2b_2", int'(got[2]), 8'hFF);
            end
            chk("b2b_word", int'(word), 8'hFF);
         end
      end

      // Stall after four data bits, then a clean frame.
      got.delete();
      send_bits(mkframe(8'hC3, 1, 1), 5, 6);
      repeat (60) @(negedge sysclk);
      send_bits(mkframe(8'h81, 1, 1), 11, 6);
      settle();
      chk("tmo_n", got.size(), 1);
      if (got.size() == 1) chk("tmo_val", int'(got[0]), 8'h81);
      chk("tmo_word", int'(word), 8'h81);

      // Reset in the middle of a frame.
      got.delete();
      send_bits(mkframe(8'h7E, 1, 1), 4, 6);
      reset = 1'b1;
      #1;
      chk("midrst_word", int'(word), 0);
      chk("midrst_done", int'(done), 0);
      repeat (3) @(negedge sysclk);
      reset = 1'b0;
      repeat (6) @(negedge sysclk);
      send_bits(mkframe(8'h7E, 1, 1), 11, 6);
      settle();
      chk("midrst_n", got.size(), 1);
      chk("midrst_rx", int'(word), 8'h7E);

      // Random frames: only frames with odd parity and a high stop bit count.
      got.delete();
      expq.delete();
      for (int k = 0; k < 40; k++) begin
         logic [7:0] d;
         bit pok, sok;
         int h;
         d   = 8'($urandom);
         pok = ($urandom_range(0, 4) != 0);
         sok = ($urandom_range(0, 5) != 0);
         h   = $urandom_range(2, 10);
         if ($urandom_range(0, 7) == 0) begin
            @(negedge sysclk);
            dat = 1'b1;
            clk = 1'b0;
            repeat (h) @(negedge sysclk);
            clk = 1'b1;
            repeat (h) @(negedge sysclk);
         end
         send_bits(mkframe(d, pok, sok), 11, h);
         if (pok && sok) expq.push_back(d);
         repeat ($urandom_range(0, 5)) @(negedge sysclk);
      end
      settle();
      chk("rand_n", got.size(), expq.size());
      for (int i = 0; i < expq.size() && i < got.size(); i++)
         chk($sformatf("rand%0d", i), int'(got[i]), int'(expq[i]));

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
